// File: rtl/mem_nack_replay_buf_pkg.sv
// Shared definitions for the memory nack/replay buffer.
// Holds the default memory-interface widths and the per-entry state encoding.
package mem_nack_replay_buf_pkg;

    localparam int unsigned MEM_ADDR_BITS = 32;
    localparam int unsigned MEM_DATA_BITS = 32;
    localparam int unsigned MEM_TAG_BITS  = 4;

    // Entry lifecycle: FREE -> ISSUE -> WAIT -> FREE, or back to ISSUE on a nack.
    typedef enum logic [1:0] {
        MNR_FREE  = 2'd0,
        MNR_ISSUE = 2'd1,
        MNR_WAIT  = 2'd2
    } mnr_state_e;

endpackage

// File: rtl/mem_nack_replay_rr_pick.sv
// Round-robin picker for the replay buffer.
// Scans the request vector starting at ptr_i and wraps around; the first set bit wins.
// Ports:
//   req_i   - one bit per entry that wants to be picked
//   ptr_i   - index with highest priority this cycle
//   valid_o - some request is set
//   grant_o - one-hot grant
//   idx_o   - index of the granted entry
module mem_nack_replay_rr_pick #(
    parameter int unsigned NUM_ENTRIES = 4,
    localparam int unsigned IdxW = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] req_i,
    input  logic [IdxW-1:0]        ptr_i,
    output logic                   valid_o,
    output logic [NUM_ENTRIES-1:0] grant_o,
    output logic [IdxW-1:0]        idx_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            // NUM_ENTRIES is a power of two, so the add wraps naturally.
            cand = ptr_i + IdxW'(i);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/mem_nack_replay_buf.sv
// Nack/replay buffer between a core memory port and the crossbar core0 port.
// Every accepted request lives in an entry until it gets a good response; a nacked
// request is re-issued. Requests whose tag or address collide with an outstanding
// entry are stalled so that replays cannot reorder accesses.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   cpu_req_*             - request from the core (val/rdy handshake)
//   cpu_resp_*            - good responses back to the core (never nacks)
//   mem_req_*             - request to the crossbar (val/rdy handshake)
//   mem_resp_*            - response / nack from the crossbar
//   outstanding           - number of non-FREE entries
module mem_nack_replay_buf
    import mem_nack_replay_buf_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned ADDR_BITS   = MEM_ADDR_BITS,
    parameter int unsigned DATA_BITS   = MEM_DATA_BITS,
    parameter int unsigned TAG_BITS    = MEM_TAG_BITS,
    localparam int unsigned IdxW = $clog2(NUM_ENTRIES),
    localparam int unsigned CntW = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req_val,
    output logic                 cpu_req_rdy,
    input  logic                 cpu_req_rw,
    input  logic [ADDR_BITS-1:0] cpu_req_addr,
    input  logic [DATA_BITS-1:0] cpu_req_data,
    input  logic [TAG_BITS-1:0]  cpu_req_tag,
    output logic                 cpu_resp_val,
    output logic [DATA_BITS-1:0] cpu_resp_data,
    output logic [TAG_BITS-1:0]  cpu_resp_tag,
    output logic                 mem_req_val,
    input  logic                 mem_req_rdy,
    output logic                 mem_req_rw,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [DATA_BITS-1:0] mem_req_data,
    output logic [TAG_BITS-1:0]  mem_req_tag,
    input  logic                 mem_resp_val,
    input  logic                 mem_resp_nack,
    input  logic [DATA_BITS-1:0] mem_resp_data,
    input  logic [TAG_BITS-1:0]  mem_resp_tag,
    output logic [CntW-1:0]      outstanding
);

    mnr_state_e           state_q [NUM_ENTRIES];
    mnr_state_e           state_d [NUM_ENTRIES];
    logic                 rw_q    [NUM_ENTRIES];
    logic [ADDR_BITS-1:0] addr_q  [NUM_ENTRIES];
    logic [DATA_BITS-1:0] data_q  [NUM_ENTRIES];
    logic [TAG_BITS-1:0]  tag_q   [NUM_ENTRIES];

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [NUM_ENTRIES-1:0] free_vec, issue_vec, tag_hit_vec, addr_hit_vec, resp_hit_vec;
    logic [IdxW-1:0]        alloc_idx;
    logic                   alloc_found;
    logic                   accept, handshake, resp_hit;

    logic                   pick_valid;
    logic [NUM_ENTRIES-1:0] pick_grant;
    logic [IdxW-1:0]        pick_idx;

    // Per-entry decode against registered state only.
    always_comb begin
        free_vec     = '0;
        issue_vec    = '0;
        tag_hit_vec  = '0;
        addr_hit_vec = '0;
        resp_hit_vec = '0;
        alloc_idx    = '0;
        alloc_found  = 1'b0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            free_vec[i]     = (state_q[i] == MNR_FREE);
            issue_vec[i]    = (state_q[i] == MNR_ISSUE);
            tag_hit_vec[i]  = !free_vec[i] && (tag_q[i] == cpu_req_tag);
            addr_hit_vec[i] = !free_vec[i] && (addr_q[i] == cpu_req_addr);
            resp_hit_vec[i] = (state_q[i] == MNR_WAIT) && (tag_q[i] == mem_resp_tag);
            if (free_vec[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = IdxW'(i);
            end
        end
    end

    mem_nack_replay_rr_pick #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_rr_pick (
        .req_i   (issue_vec),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    always_comb begin
        cpu_req_rdy = !reset && alloc_found && !(|tag_hit_vec) && !(|addr_hit_vec);
        accept      = cpu_req_val && cpu_req_rdy;

        // Fields come straight from the picked entry, so they stay put until a
        // handshake moves the pointer or a higher-priority entry becomes eligible.
        mem_req_val  = !reset && pick_valid;
        mem_req_rw   = rw_q[pick_idx];
        mem_req_addr = addr_q[pick_idx];
        mem_req_data = data_q[pick_idx];
        mem_req_tag  = tag_q[pick_idx];
        handshake    = mem_req_val && mem_req_rdy;

        resp_hit      = |resp_hit_vec;
        cpu_resp_val  = !reset && mem_resp_val && resp_hit;
        cpu_resp_data = mem_resp_data;
        cpu_resp_tag  = mem_resp_tag;

        outstanding = reset ? '0 : cnt_q;
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                MNR_FREE: begin
                    if (accept && (alloc_idx == IdxW'(i))) state_d[i] = MNR_ISSUE;
                end
                MNR_ISSUE: begin
                    if (handshake && pick_grant[i]) state_d[i] = MNR_WAIT;
                end
                MNR_WAIT: begin
                    if (resp_hit_vec[i] && mem_resp_val) begin
                        state_d[i] = MNR_FREE;
                    end else if (resp_hit_vec[i] && mem_resp_nack) begin
                        state_d[i] = MNR_ISSUE;
                    end
                end
                default: state_d[i] = MNR_FREE;
            endcase
        end
        ptr_d = handshake ? pick_idx + IdxW'(1) : ptr_q;
        cnt_d = cnt_q + CntW'(accept) - CntW'(cpu_resp_val);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) state_q[i] <= MNR_FREE;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) state_q[i] <= state_d[i];
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload needs no reset: it is only read while the entry is non-FREE.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (accept && (alloc_idx == IdxW'(i))) begin
                rw_q[i]   <= cpu_req_rw;
                addr_q[i] <= cpu_req_addr;
                data_q[i] <= cpu_req_data;
                tag_q[i]  <= cpu_req_tag;
            end
        end
    end

endmodule

// File: tb/tb_mem_nack_replay_buf.sv
// Directed self-checking bench for mem_nack_replay_buf (4 entries, 32/32/4-bit fields).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_mem_nack_replay_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req_val, cpu_req_rdy, cpu_req_rw;
    logic [31:0] cpu_req_addr, cpu_req_data;
    logic [3:0]  cpu_req_tag;
    logic        cpu_resp_val;
    logic [31:0] cpu_resp_data;
    logic [3:0]  cpu_resp_tag;
    logic        mem_req_val, mem_req_rdy, mem_req_rw;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [3:0]  mem_req_tag;
    logic        mem_resp_val, mem_resp_nack;
    logic [31:0] mem_resp_data;
    logic [3:0]  mem_resp_tag;
    logic [2:0]  outstanding;

    int n_tests = 0;
    int n_fail  = 0;

    // Event log filled by the monitor below.
    int          hs_cnt = 0, resp_cnt = 0, nack_leak = 0, drop_cnt = 0;
    logic [31:0] hs_addr [$];
    logic [31:0] hs_data [$];
    logic [3:0]  hs_tag  [$];
    logic        allow_drop = 1'b0;

    always #5 clk = ~clk;

    mem_nack_replay_buf #(
        .NUM_ENTRIES (4),
        .ADDR_BITS   (32),
        .DATA_BITS   (32),
        .TAG_BITS    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req_val   (cpu_req_val),
        .cpu_req_rdy   (cpu_req_rdy),
        .cpu_req_rw    (cpu_req_rw),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_data  (cpu_req_data),
        .cpu_req_tag   (cpu_req_tag),
        .cpu_resp_val  (cpu_resp_val),
        .cpu_resp_data (cpu_resp_data),
        .cpu_resp_tag  (cpu_resp_tag),
        .mem_req_val   (mem_req_val),
        .mem_req_rdy   (mem_req_rdy),
        .mem_req_rw    (mem_req_rw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_tag   (mem_req_tag),
        .mem_resp_val  (mem_resp_val),
        .mem_resp_nack (mem_resp_nack),
        .mem_resp_data (mem_resp_data),
        .mem_resp_tag  (mem_resp_tag),
        .outstanding   (outstanding)
    );

    always @(negedge clk) begin
        #2;
        if (!reset && mem_req_val && mem_req_rdy) begin
            hs_cnt++;
            hs_addr.push_back(mem_req_addr);
            hs_data.push_back(mem_req_data);
            hs_tag.push_back(mem_req_tag);
        end
        if (cpu_resp_val) resp_cnt++;
        if (cpu_resp_val && mem_resp_nack) nack_leak++;
        if (!reset && mem_resp_val && !cpu_resp_val && !allow_drop) drop_cnt++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        cpu_req_val   = 1'b0;
        mem_resp_val  = 1'b0;
        mem_resp_nack = 1'b0;
    endtask

    task automatic drive_req(input logic rw, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] tag);
        cpu_req_val  = 1'b1;
        cpu_req_rw   = rw;
        cpu_req_addr = addr;
        cpu_req_data = data;
        cpu_req_tag  = tag;
    endtask

    task automatic drive_resp(input logic [3:0] tag, input logic [31:0] data, input logic nack);
        mem_resp_val  = !nack;
        mem_resp_nack = nack;
        mem_resp_tag  = tag;
        mem_resp_data = data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        mem_req_rdy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        mem_req_rdy = 1'b1;
        tick();
        #1;
        n_tests++; if (cpu_req_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_req_rdy got %b exp 0", cpu_req_rdy); end
        n_tests++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL rst_mem_val got %b exp 0", mem_req_val); end
        n_tests++; if (cpu_resp_val !== 1'b0) begin n_fail++; $display("FAIL rst_resp_val got %b exp 0", cpu_resp_val); end
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rst_outstanding got %0d exp 0", outstanding); end
        tick();
        reset = 1'b0;
        #1;
        n_tests++; if (cpu_req_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_rdy got %b exp 1", cpu_req_rdy); end
        n_tests++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL post_rst_mem_val got %b exp 0", mem_req_val); end
        tick();
    endtask

    task automatic test_basic_read();
        mem_req_rdy = 1'b1;
        drive_req(1'b0, 32'h40, 32'h0, 4'd3);
        #1;
        n_tests++; if (cpu_req_rdy !== 1'b1) begin n_fail++; $display("FAIL rd_accept got %b exp 1", cpu_req_rdy); end
        n_tests++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL rd_no_cut_through got %b exp 0", mem_req_val); end
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rd_out0 got %0d exp 0", outstanding); end
        tick();
        clear_inputs();
        #1;
        n_tests++; if (mem_req_val !== 1'b1) begin n_fail++; $display("FAIL rd_issue_val got %b exp 1", mem_req_val); end
        n_tests++; if (mem_req_tag !== 4'd3) begin n_fail++; $display("FAIL rd_issue_tag got %0d exp 3", mem_req_tag); end
        n_tests++; if (mem_req_addr !== 32'h40) begin n_fail++; $display("FAIL rd_issue_addr got %0h exp 40", mem_req_addr); end
        n_tests++; if (mem_req_rw !== 1'b0) begin n_fail++; $display("FAIL rd_issue_rw got %b exp 0", mem_req_rw); end
        n_tests++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL rd_out1 got %0d exp 1", outstanding); end
        tick();
        drive_resp(4'd3, 32'hABCD, 1'b0);
        #1;
        n_tests++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL rd_wait_idle got %b exp 0", mem_req_val); end
        n_tests++; if (cpu_resp_val !== 1'b1) begin n_fail++; $display("FAIL rd_resp_val got %b exp 1", cpu_resp_val); end
        n_tests++; if (cpu_resp_data !== 32'hABCD) begin n_fail++; $display("FAIL rd_resp_data got %0h exp abcd", cpu_resp_data); end
        n_tests++; if (cpu_resp_tag !== 4'd3) begin n_fail++; $display("FAIL rd_resp_tag got %0d exp 3", cpu_resp_tag); end
        tick();
        clear_inputs();
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rd_out_end got %0d exp 0", outstanding); end
        tick();
    endtask

    task automatic test_nack_replay();
        int hs_base   = hs_cnt;
        int resp_base = resp_cnt;
        mem_req_rdy = 1'b1;
        drive_req(1'b1, 32'h80, 32'h12345678, 4'd5);
        #1;
        n_tests++; if (cpu_req_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_accept got %b exp 1", cpu_req_rdy); end
        tick();
        clear_inputs();
        #1;
        n_tests++; if (mem_req_rw !== 1'b1) begin n_fail++; $display("FAIL wr_rw got %b exp 1", mem_req_rw); end
        tick();
        for (int k = 0; k < 2; k++) begin
            drive_resp(4'd5, 32'h0, 1'b1);
            #1;
            n_tests++; if (cpu_resp_val !== 1'b0) begin n_fail++; $display("FAIL wr_nack_hidden got %b exp 0", cpu_resp_val); end
            tick();
            clear_inputs();
            #1;
            n_tests++; if (mem_req_val !== 1'b1) begin n_fail++; $display("FAIL wr_reissue got %b exp 1", mem_req_val); end
            tick();
        end
        drive_resp(4'd5, 32'hFEED, 1'b0);
        #1;
        n_tests++; if (cpu_resp_val !== 1'b1) begin n_fail++; $display("FAIL wr_ack got %b exp 1", cpu_resp_val); end
        tick();
        clear_inputs();
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL wr_out_end got %0d exp 0", outstanding); end
        n_tests++; if (hs_cnt - hs_base !== 3) begin n_fail++; $display("FAIL wr_hs_count got %0d exp 3", hs_cnt - hs_base); end
        n_tests++; if (resp_cnt - resp_base !== 1) begin n_fail++; $display("FAIL wr_resp_count got %0d exp 1", resp_cnt - resp_base); end
        for (int k = hs_base; k < hs_cnt; k++) begin
            n_tests++;
            if (hs_addr[k] !== 32'h80 || hs_data[k] !== 32'h12345678 || hs_tag[k] !== 4'd5) begin
                n_fail++;
                $display("FAIL wr_replay_fields got %0h/%0h/%0d exp 80/12345678/5", hs_addr[k], hs_data[k], hs_tag[k]);
            end
        end
        tick();
    endtask

    task automatic test_fill();
        logic [3:0] ack_tags [4];
        ack_tags[0] = 4'd0; ack_tags[1] = 4'd2; ack_tags[2] = 4'd3; ack_tags[3] = 4'd4;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b0, 32'h100 + 32'(16 * i), 32'h0, 4'(i));
            #1;
            n_tests++; if (cpu_req_rdy !== 1'b1) begin n_fail++; $display("FAIL fill_accept%0d got %b exp 1", i, cpu_req_rdy); end
            tick();
        end
        drive_req(1'b0, 32'h140, 32'h0, 4'd4);
        #1;
        n_tests++; if (cpu_req_rdy !== 1'b0) begin n_fail++; $display("FAIL fill_full_rdy got %b exp 0", cpu_req_rdy); end
        n_tests++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL fill_out4 got %0d exp 4", outstanding); end
        tick();
        mem_req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (mem_req_tag !== 4'(i)) begin n_fail++; $display("FAIL fill_issue%0d got %0d exp %0d", i, mem_req_tag, i); end
            tick();
        end
        mem_req_rdy = 1'b0;
        drive_resp(4'd1, 32'h11, 1'b0);
        #1;
        n_tests++; if (cpu_req_rdy !== 1'b0) begin n_fail++; $display("FAIL fill_ack_same_cycle got %b exp 0", cpu_req_rdy); end
        n_tests++; if (cpu_resp_val !== 1'b1) begin n_fail++; $display("FAIL fill_ack1 got %b exp 1", cpu_resp_val); end
        tick();
        mem_resp_val = 1'b0;
        #1;
        n_tests++; if (cpu_req_rdy !== 1'b1) begin n_fail++; $display("FAIL fill_reopen got %b exp 1", cpu_req_rdy); end
        tick();
        cpu_req_val = 1'b0;
        mem_req_rdy = 1'b1;
        #1;
        n_tests++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL fill_refill got %0d exp 4", outstanding); end
        n_tests++; if (mem_req_tag !== 4'd4) begin n_fail++; $display("FAIL fill_issue_t4 got %0d exp 4", mem_req_tag); end
        tick();
        mem_req_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_resp(ack_tags[i], 32'h0, 1'b0);
            #1;
            n_tests++; if (cpu_resp_val !== 1'b1) begin n_fail++; $display("FAIL fill_drain t%0d got %b exp 1", ack_tags[i], cpu_resp_val); end
            tick();
        end
        clear_inputs();
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL fill_out_end got %0d exp 0", outstanding); end
        tick();
    endtask

    task automatic test_conflict();
        do_reset();
        mem_req_rdy = 1'b1;
        drive_req(1'b0, 32'h200, 32'h0, 4'd7);
        tick();
        drive_req(1'b0, 32'h200, 32'h0, 4'd8);
        #1;
        n_tests++; if (cpu_req_rdy !== 1'b0) begin n_fail++; $display("FAIL cf_addr_issue got %b exp 0", cpu_req_rdy); end
        tick();
        drive_req(1'b0, 32'h300, 32'h0, 4'd7);
        #1;
        n_tests++; if (cpu_req_rdy !== 1'b0) begin n_fail++; $display("FAIL cf_tag_dup got %b exp 0", cpu_req_rdy); end
        tick();
        cpu_req_val = 1'b0;
        cpu_req_tag = 4'd8;
        #1;
        n_tests++; if (cpu_req_rdy !== 1'b1) begin n_fail++; $display("FAIL cf_no_conflict got %b exp 1", cpu_req_rdy); end
        tick();
        drive_req(1'b0, 32'h200, 32'h0, 4'd8);
        drive_resp(4'd7, 32'h77, 1'b0);
        #1;
        n_tests++; if (cpu_req_rdy !== 1'b0) begin n_fail++; $display("FAIL cf_ack_cycle got %b exp 0", cpu_req_rdy); end
        n_tests++; if (cpu_resp_val !== 1'b1) begin n_fail++; $display("FAIL cf_ack7 got %b exp 1", cpu_resp_val); end
        tick();
        mem_resp_val = 1'b0;
        #1;
        n_tests++; if (cpu_req_rdy !== 1'b1) begin n_fail++; $display("FAIL cf_release got %b exp 1", cpu_req_rdy); end
        tick();
        clear_inputs();
        #1;
        n_tests++; if (mem_req_tag !== 4'd8 || mem_req_val !== 1'b1) begin
            n_fail++; $display("FAIL cf_issue8 got %b/%0d exp 1/8", mem_req_val, mem_req_tag);
        end
        tick();
        drive_resp(4'd8, 32'h88, 1'b0);
        #1;
        n_tests++; if (cpu_resp_val !== 1'b1) begin n_fail++; $display("FAIL cf_ack8 got %b exp 1", cpu_resp_val); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        logic       rdy_seq [8];
        logic [3:0] tag_seq [8];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b0, 32'h400 + 32'(16 * i), 32'h0, 4'(i));
            tick();
        end
        clear_inputs();
        // rdy toggles; entry 0 is nacked during step 2 and must come back after 2.
        rdy_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tag_seq = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0, 4'd0};
        for (int s = 0; s < 8; s++) begin
            mem_req_rdy = rdy_seq[s];
            if (s == 2) drive_resp(4'd0, 32'h0, 1'b1);
            else        clear_inputs();
            #1;
            n_tests++; if (mem_req_val !== 1'b1 || mem_req_tag !== tag_seq[s]) begin
                n_fail++; $display("FAIL rr_step%0d got %b/%0d exp 1/%0d", s, mem_req_val, mem_req_tag, tag_seq[s]);
            end
            tick();
        end
        mem_req_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_resp(4'(i), 32'h0, 1'b0);
            #1;
            n_tests++; if (cpu_resp_val !== 1'b1) begin n_fail++; $display("FAIL rr_drain%0d got %b exp 1", i, cpu_resp_val); end
            tick();
        end
        clear_inputs();
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rr_out_end got %0d exp 0", outstanding); end
        tick();
    endtask

    task automatic test_reset_outstanding();
        do_reset();
        mem_req_rdy = 1'b1;
        drive_req(1'b0, 32'h500, 32'h0, 4'd9);
        tick();
        drive_req(1'b0, 32'h510, 32'h0, 4'd10);
        tick();
        clear_inputs();
        #1;
        n_tests++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL ro_out2 got %0d exp 2", outstanding); end
        tick();
        reset = 1'b1;
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL ro_during_rst got %0d exp 0", outstanding); end
        tick();
        reset = 1'b0;
        allow_drop = 1'b1;
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL ro_after_rst got %0d exp 0", outstanding); end
        tick();
        drive_resp(4'd9, 32'h99, 1'b0);
        #1;
        n_tests++; if (cpu_resp_val !== 1'b0) begin n_fail++; $display("FAIL ro_late9 got %b exp 0", cpu_resp_val); end
        tick();
        drive_resp(4'd10, 32'h1010, 1'b0);
        #1;
        n_tests++; if (cpu_resp_val !== 1'b0) begin n_fail++; $display("FAIL ro_late10 got %b exp 0", cpu_resp_val); end
        tick();
        clear_inputs();
        tick();
        allow_drop = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        mem_req_rdy   = 1'b0;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_data  = '0;
        cpu_req_tag   = '0;
        mem_resp_tag  = '0;
        mem_resp_data = '0;
        clear_inputs();
        test_reset();
        test_basic_read();
        test_nack_replay();
        test_fill();
        test_conflict();
        test_round_robin();
        test_reset_outstanding();
        n_tests++; if (nack_leak !== 0) begin n_fail++; $display("FAIL nack_leak got %0d exp 0", nack_leak); end
        n_tests++; if (drop_cnt !== 0) begin n_fail++; $display("FAIL dropped_resp got %0d exp 0", drop_cnt); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_nack_replay_buf.md
Name: mem_nack_replay_buf

Overview:
- Sits between a core's memory port and the core0 request/response port of the scalar core/L2 crossbar.
- Tracks every outstanding request in a small entry table and re-issues any request the crossbar reports as nacked.
- Forwards successful responses back to the core unchanged.
- Also stalls the core on tag or address conflicts, so that retries cannot cause reordering.

Parameters:
- NUM_ENTRIES, 4, outstanding-request table depth (power of 2, 2..8)
- ADDR_BITS, `MEM_ADDR_BITS, request address width
- DATA_BITS, `MEM_DATA_BITS, data width
- TAG_BITS, `MEM_TAG_BITS, core tag width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_req_val  in  1  core request valid
- cpu_req_rdy  out  1  buffer can accept the request
- cpu_req_rw  in  1  1 = write
- cpu_req_addr  in  ADDR_BITS  request address
- cpu_req_data  in  DATA_BITS  write data
- cpu_req_tag  in  TAG_BITS  request tag
- cpu_resp_val  out  1  response to core
- cpu_resp_data  out  DATA_BITS  response data
- cpu_resp_tag  out  TAG_BITS  response tag
- mem_req_val  out  1  to crossbar core0_req_val
- mem_req_rdy  in  1  from crossbar core0_req_rdy
- mem_req_rw  out  1  request type
- mem_req_addr  out  ADDR_BITS  request address
- mem_req_data  out  DATA_BITS  write data
- mem_req_tag  out  TAG_BITS  request tag
- mem_resp_val  in  1  crossbar response valid
- mem_resp_nack  in  1  crossbar nack
- mem_resp_data  in  DATA_BITS  response data
- mem_resp_tag  in  TAG_BITS  response tag
- outstanding  out  $clog2(NUM_ENTRIES+1)  count of non-FREE entries

Behaviour:
- Single clock; reset is synchronous and active-high. Reset forces all entries FREE and the round-robin pointer to 0.
- Outputs during the reset cycle: cpu_req_rdy=0, mem_req_val=0, cpu_resp_val=0, outstanding=0.
- Each entry holds rw, addr, data, tag and a 2-bit state.
- Entry states and transitions:
  - FREE -> ISSUE: on allocation.
  - ISSUE -> WAIT: when mem_req_val & mem_req_rdy for this entry.
  - WAIT -> FREE: mem_resp_val and tag match.
  - WAIT -> ISSUE: mem_resp_nack and tag match.
- Allocation:
  - cpu_req_rdy = ~reset & (some entry FREE) & no tag match against any non-FREE entry & no addr match against any non-FREE entry.
  - On accept, the lowest-index FREE entry is written.
  - Free status comes from registered state only; an entry freed this cycle is reusable next cycle.
- Issue:
  - mem_req_val = any entry in ISSUE. The chosen entry is picked round-robin starting at the pointer.
  - The pointer advances to chosen+1 (mod NUM_ENTRIES) on a handshake.
  - mem_req_* fields hold stable while val is high and rdy is low, unless a higher-priority entry enters ISSUE. A re-selection is legal only while rdy=0.
- Latency: a request accepted in cycle N is presented on mem_req no earlier than N+1 (no cut-through).
- Responses:
  - cpu_resp_val = mem_resp_val & tag hits a WAIT entry (combinational, same cycle).
  - cpu_resp_data and cpu_resp_tag pass through from mem_resp.
  - A nack is never forwarded to the core.
  - mem_resp_val and mem_resp_nack are never both high. Writes also receive exactly one response or nack.
  - A response or nack whose tag hits no WAIT entry is dropped, including responses to requests issued before a reset. The bench asserts that this never happens outside reset recovery.
- Simultaneous events:
  - Accept, issue and response/nack may all occur in one cycle on distinct entries.
  - A nacked entry is eligible for issue the cycle after the nack.
  - The round-robin pick prevents a repeatedly nacked entry from starving others.
- outstanding: registered popcount of non-FREE entries. Updated every cycle with +1 on accept and -1 on good response; both in one cycle leaves it unchanged.

Decomposition:
- Shared header (`define style, alongside existing memory-interface defines): entry-state encodings MNR_FREE=2'd0, MNR_ISSUE=2'd1, MNR_WAIT=2'd2.
- Sub-module mem_nack_replay_rr_pick: takes an NUM_ENTRIES-bit request vector plus a pointer and returns a one-hot grant and an index. It is purely combinational.

Test Plan:
- Reset, then read tag 3 at addr 0x40 with mem_req_rdy=1 -> mem_req_val in the next cycle with tag 3. A later resp (tag 3, data 0xABCD) gives a same-cycle cpu_resp_val with data 0xABCD, and outstanding goes 0->1->0.
- Write tag 5 nacked twice, then acked -> exactly 3 mem_req handshakes with identical addr/data, one cpu_resp_val, and no nack visible to the core.
- Fill 4 entries (tags 0-3, distinct addrs) with mem_req_rdy=0 -> cpu_req_rdy=0 on the 5th request. An ack for tag 1 re-opens rdy on the following cycle.
- A request with the same addr as an outstanding entry, or a duplicate tag -> cpu_req_rdy=0 until that entry is acked.
- Entries 0-2 in ISSUE with rdy toggling -> grants in round-robin order 0,1,2. A nack on entry 0 mid-stream causes it to reissue after 2, not before.
- Reset asserted with 2 requests outstanding -> outstanding=0 next cycle, and late responses for those tags produce no cpu_resp_val.
